param_sequencer: RTL and testbench

PARAM_SEQUENCER -- requirements
Module: param_sequencer

---
 rtl/param_sequencer.sv | 120 ++++++++++++
 tb/tb_param_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sequencer.sv
// param_sequencer: fetches 5-byte parameter records from memory, streams them to a register block and paces playback by frame sync.
module param_sequencer (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        ABORT,
  input  logic        LOOP,
  input  logic [15:0] BASE_ADDR,
  input  logic [7:0]  NUM_REC,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_RD,
  input  logic [7:0]  MEM_DATA,
  input  logic        MEM_ACK,
  output logic [7:0]  RByt0,
  output logic        Valid,
  input  logic        FINISH_READ,
  input  logic        FINISH,
  output logic        NEXT,
  input  logic        VSYNC,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  REC_IDX
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PUSH_HI, S_PUSH_LO, S_WAIT_LOADED, S_PLAY, S_ADVANCE, S_DONE
  } state_t;
  state_t      state;
  logic [7:0]  num_q;
  logic [15:0] base_q;
  logic [2:0]  byte_idx;
  logic [3:0]  tcnt;
  logic        phase;
  logic        vs_q;
  logic [7:0]  rec_nx;
  logic        wrap;
  assign rec_nx = REC_IDX + 8'd1;
  assign wrap   = rec_nx == num_q;
  assign BUSY   = state != S_IDLE && state != S_DONE;
  assign DONE   = state == S_DONE;
  // MEM_ADDR is kept equal to base + 5*REC_IDX + byte_idx by stepping it alongside the indices.
  always_ff @(posedge ACLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      MEM_ADDR <= '0;
      MEM_RD   <= 1'b0;
      RByt0    <= '0;
      Valid    <= 1'b0;
      NEXT     <= 1'b0;
      ERR      <= 1'b0;
      REC_IDX  <= '0;
      num_q    <= '0;
      base_q   <= '0;
      byte_idx <= '0;
      tcnt     <= '0;
      phase    <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      vs_q   <= VSYNC;
      MEM_RD <= 1'b0;
      NEXT   <= 1'b0;
      if (ABORT) begin
        state <= S_IDLE;
        Valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: if (START) begin
            num_q  <= NUM_REC;
            base_q <= BASE_ADDR;
            if (NUM_REC == 8'd0) state <= S_DONE;
            else begin
              REC_IDX  <= '0;
              byte_idx <= '0;
              ERR      <= 1'b0;
              MEM_ADDR <= BASE_ADDR;
              MEM_RD   <= 1'b1;
              tcnt     <= '0;
              state    <= S_FETCH;
            end
          end
          // The read strobe occupies FETCH cycle 0; ERR shows 16 cycles after it.
          S_FETCH: if (MEM_ACK) begin
            RByt0 <= MEM_DATA;
            Valid <= 1'b1;
            phase <= 1'b0;
            state <= S_PUSH_HI;
          end else if (tcnt == 4'd15) begin
            ERR   <= 1'b1;
            state <= S_IDLE;
          end else tcnt <= tcnt + 4'd1;
          S_PUSH_HI: begin
            phase <= ~phase;
            Valid <= ~phase;
            state <= phase ? S_PUSH_LO : S_PUSH_HI;
          end
          S_PUSH_LO: if (!phase) phase <= 1'b1;
          else begin
            phase    <= 1'b0;
            byte_idx <= byte_idx == 3'd4 ? 3'd0 : byte_idx + 3'd1;
            MEM_ADDR <= byte_idx == 3'd4 ? MEM_ADDR - 16'd4 : MEM_ADDR + 16'd1;
            MEM_RD   <= byte_idx != 3'd4;
            tcnt     <= '0;
            state    <= byte_idx == 3'd4 ? S_WAIT_LOADED : S_FETCH;
          end
          S_WAIT_LOADED: if (FINISH_READ) state <= S_PLAY;
          S_PLAY: if (FINISH) state <= S_ADVANCE;
          else NEXT <= VSYNC & ~vs_q;
          S_ADVANCE: begin
            state    <= wrap && !LOOP ? S_DONE : S_FETCH;
            MEM_RD   <= !(wrap && !LOOP);
            REC_IDX  <= wrap && LOOP ? 8'd0 : rec_nx;
            MEM_ADDR <= wrap && LOOP ? base_q : MEM_ADDR + 16'd5;
            tcnt     <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_param_sequencer.sv
// tb_param_sequencer: table, random and directed checks of param_sequencer against a record-level model.
module tb_param_sequencer;
  logic        ACLK = 1'b0;
  logic        RESET, START, ABORT, LOOP;
  logic [15:0] BASE_ADDR;
  logic [7:0]  NUM_REC;
  logic [15:0] MEM_ADDR;
  logic        MEM_RD;
  logic [7:0]  MEM_DATA;
  logic        MEM_ACK;
  logic [7:0]  RByt0;
  logic        Valid, FINISH_READ, FINISH, NEXT, VSYNC, BUSY, DONE, ERR;
  logic [7:0]  REC_IDX;

  param_sequencer dut (
    .ACLK(ACLK), .RESET(RESET), .START(START), .ABORT(ABORT), .LOOP(LOOP),
    .BASE_ADDR(BASE_ADDR), .NUM_REC(NUM_REC), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_DATA(MEM_DATA), .MEM_ACK(MEM_ACK), .RByt0(RByt0), .Valid(Valid),
    .FINISH_READ(FINISH_READ), .FINISH(FINISH), .NEXT(NEXT), .VSYNC(VSYNC),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .REC_IDX(REC_IDX)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0, fails = 0;
  logic [7:0] seed;
  int  ack_lat;
  bit  ack_en;

  int          cyc;
  int          rd_t[$], rise_t[$], fall_t[$];
  logic [15:0] rd_a[$];
  logic [7:0]  bytes_q[$];
  int          next_hi, next_rise;
  bit          byte_moved;
  logic        prev_valid, prev_next;
  logic [7:0]  prev_byte;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  num;
    int          lat;
    int          nvs;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return 8'(a[7:0] * 8'd37 + a[15:8] + seed);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: answers each read strobe after ack_lat further cycles
  initial begin
    MEM_ACK = 1'b0;
    MEM_DATA = '0;
    forever begin
      logic [15:0] a;
      @(negedge ACLK);
      MEM_ACK = 1'b0;
      if (MEM_RD === 1'b1 && ack_en) begin
        a = MEM_ADDR;
        repeat (ack_lat) @(negedge ACLK);
        MEM_DATA = mem_byte(a);
        MEM_ACK = 1'b1;
      end
    end
  end

  initial begin
    cyc = 0; prev_valid = 1'b0; prev_next = 1'b0; prev_byte = '0;
    forever begin
      @(posedge ACLK); #1;
      cyc++;
      if (MEM_RD === 1'b1) begin rd_t.push_back(cyc); rd_a.push_back(MEM_ADDR); end
      if (NEXT === 1'b1) next_hi++;
      if (NEXT === 1'b1 && prev_next !== 1'b1) next_rise++;
      if (Valid === 1'b1 && prev_valid !== 1'b1) begin rise_t.push_back(cyc); bytes_q.push_back(RByt0); end
      else if (RByt0 !== prev_byte) byte_moved = 1'b1;
      if (Valid === 1'b0 && prev_valid === 1'b1) fall_t.push_back(cyc);
      prev_valid = Valid; prev_next = NEXT; prev_byte = RByt0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rd_t.delete(); rd_a.delete(); rise_t.delete(); fall_t.delete(); bytes_q.delete();
    next_hi = 0; next_rise = 0; byte_moved = 1'b0;
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rise_t.size() >= n) ok = 1'b1;
      else @(negedge ACLK);
    end
    if (!ok) chk("valid_pulse_timeout", rise_t.size(), n);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_addr"}, MEM_ADDR, 0);
    chk({tag, "_mem_rd"}, MEM_RD, 0);
    chk({tag, "_rbyt0"}, RByt0, 0);
    chk({tag, "_valid"}, Valid, 0);
    chk({tag, "_next"}, NEXT, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_rec_idx"}, REC_IDX, 0);
  endtask

  task automatic start_seq(input logic [15:0] base, input logic [7:0] num);
    @(negedge ACLK);
    BASE_ADDR = base; NUM_REC = num; START = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
  endtask

  task automatic load_record(input int r, output bit ok);
    wait_rises(5 * (r + 1), ok);
    if (ok) begin
      repeat (6) @(negedge ACLK);
      chk("rec_idx_loaded", REC_IDX, r);
      FINISH_READ = 1'b1;
      @(negedge ACLK);
      FINISH_READ = 1'b0;
    end
  endtask

  task automatic run_seq(input logic [15:0] base, input logic [7:0] num, input int lat, input int nvs);
    bit ok;
    int n;
    logic [15:0] ea;
    clear_mon();
    ack_lat = lat; ack_en = 1'b1; LOOP = 1'b0;
    start_seq(base, num);
    for (int r = 0; r < int'(num); r++) begin
      load_record(r, ok);
      if (!ok) return;
      for (int k = 0; k < nvs; k++) begin
        VSYNC = 1'b1; @(negedge ACLK);
        VSYNC = 1'b0; @(negedge ACLK);
      end
      @(negedge ACLK);
      FINISH = 1'b1; @(negedge ACLK);
      FINISH = 1'b0;
    end
    repeat (3) @(negedge ACLK);
    chk("end_done", DONE, 1);
    chk("end_busy", BUSY, 0);
    chk("end_rec_idx", REC_IDX, num);
    chk("next_cycles", next_hi, int'(num) * nvs);
    chk("next_pulses", next_rise, int'(num) * nvs);
    chk("rbyt0_changed_outside_valid", byte_moved, 0);
    chk("read_count", rd_a.size(), 5 * int'(num));
    n = 5 * int'(num);
    if (rd_a.size() < n) n = rd_a.size();
    if (bytes_q.size() < n) n = bytes_q.size();
    if (fall_t.size() < n) n = fall_t.size();
    for (int i = 0; i < n; i++) begin
      ea = 16'(base + 16'(5 * (i / 5)) + 16'(i % 5));
      chk("read_addr", rd_a[i], ea);
      chk("byte_value", bytes_q[i], mem_byte(ea));
      chk("valid_high_cycles", fall_t[i] - rise_t[i], 2);
      chk("ack_to_valid", rise_t[i] - rd_t[i], lat + 1);
      if (i % 5 != 4 && i + 1 < rd_t.size()) chk("valid_low_cycles", rd_t[i + 1] - fall_t[i], 2);
    end
  endtask

  initial begin
    bit ok;
    int t_rd, t_err;
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; LOOP = 1'b0;
    BASE_ADDR = '0; NUM_REC = '0; FINISH_READ = 1'b0; FINISH = 1'b0; VSYNC = 1'b0;
    ack_en = 1'b1; ack_lat = 1; seed = 8'($urandom);
    vecs[0] = '{16'h0100, 8'd2, 1, 3, 16'h0100, 16'h0109};
    vecs[1] = '{16'hFFFE, 8'd1, 1, 0, 16'hFFFE, 16'h0002};
    vecs[2] = '{16'h1234, 8'd3, 0, 2, 16'h1234, 16'h1242};
    vecs[3] = '{16'h8000, 8'd1, 15, 1, 16'h8000, 16'h8004};

    START = 1'b1; ABORT = 1'b1;
    repeat (3) @(negedge ACLK);
    check_zero("reset");
    RESET = 1'b0; START = 1'b0; ABORT = 1'b0;
    repeat (2) @(negedge ACLK);

    for (int v = 0; v < 4; v++) begin
      run_seq(vecs[v].base, vecs[v].num, vecs[v].lat, vecs[v].nvs);
      if (rd_a.size() == 0) chk("any_read", 0, 1);
      else begin
        chk("first_addr", rd_a[0], vecs[v].first);
        chk("last_addr", rd_a[rd_a.size() - 1], vecs[v].last);
      end
    end

    for (int s = 0; s < 5; s++)
      run_seq(16'($urandom), 8'($urandom_range(1, 3)), $urandom_range(0, 6), $urandom_range(0, 3));

    // read never acknowledged
    clear_mon(); ack_en = 1'b0;
    start_seq(16'h4000, 8'd2);
    t_rd = -1; t_err = -1;
    for (int i = 0; i < 60 && t_err < 0; i++) begin
      if (MEM_RD === 1'b1 && t_rd < 0) t_rd = i;
      if (ERR === 1'b1) t_err = i;
      else @(negedge ACLK);
    end
    chk("timeout_cycles", t_err - t_rd, 16);
    chk("timeout_busy", BUSY, 0);
    chk("timeout_err", ERR, 1);
    chk("timeout_reads", rd_a.size(), 1);
    ack_en = 1'b1; ack_lat = 1;
    start_seq(16'h4000, 8'd1);
    chk("restart_err_cleared", ERR, 0);
    chk("restart_busy", BUSY, 1);
    ABORT = 1'b1; @(negedge ACLK); ABORT = 1'b0;
    chk("abort_fetch_busy", BUSY, 0);
    repeat (20) @(negedge ACLK);

    // looping single record with FINISH colliding with a VSYNC edge
    clear_mon(); LOOP = 1'b1;
    start_seq(16'h2222, 8'd1);
    load_record(0, ok);
    if (ok) begin
      VSYNC = 1'b1; FINISH = 1'b1; @(negedge ACLK);
      VSYNC = 1'b0; FINISH = 1'b0;
      for (int i = 0; i < 100 && rd_a.size() < 6; i++) @(negedge ACLK);
      if (rd_a.size() < 6) chk("loop_refetch_seen", rd_a.size(), 6);
      else chk("loop_refetch_addr", rd_a[5], 16'h2222);
      chk("loop_rec_idx", REC_IDX, 0);
      chk("loop_done", DONE, 0);
      chk("loop_busy", BUSY, 1);
      chk("finish_beats_vsync_next", next_hi, 0);
    end
    ABORT = 1'b1; @(negedge ACLK); ABORT = 1'b0; LOOP = 1'b0;
    repeat (20) @(negedge ACLK);

    // abort while a byte is being presented
    clear_mon(); ack_lat = 2;
    start_seq(16'h3000, 8'd1);
    wait_rises(1, ok);
    if (ok) begin
      ABORT = 1'b1; @(negedge ACLK); ABORT = 1'b0;
      chk("abort_push_valid", Valid, 0);
      chk("abort_push_busy", BUSY, 0);
      chk("abort_push_mem_rd", MEM_RD, 0);
    end
    repeat (20) @(negedge ACLK);

    // reset while playing a frame
    clear_mon(); ack_lat = 1;
    start_seq(16'h5555, 8'd2);
    load_record(0, ok);
    VSYNC = 1'b1; @(negedge ACLK);
    RESET = 1'b1; @(negedge ACLK);
    check_zero("play_reset");
    RESET = 1'b0; VSYNC = 1'b0;
    repeat (2) @(negedge ACLK);

    // empty sequence
    clear_mon();
    start_seq(16'h0100, 8'd0);
    repeat (5) @(negedge ACLK);
    chk("empty_done", DONE, 1);
    chk("empty_busy", BUSY, 0);
    chk("empty_reads", rd_a.size(), 0);
    ABORT = 1'b1; @(negedge ACLK); ABORT = 1'b0;
    chk("empty_abort_done", DONE, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
